// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Purpose : Shared constants and helpers for the single-clock FIFO.
//           Default geometry and the pointer-width helper (address bits plus
//           one wrap bit).
// Ports   : none (package)
// Config  : SYNC_FIFO_ERR_FLAGS_EN is consumed by sync_fifo_if / sync_fifo.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 32;

  // Pointer width: enough bits to address DEPTH words, plus a wrap bit that
  // separates "full" from "empty" when the address bits are equal.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if
// Purpose : Producer/consumer side signals of sync_fifo, grouped as one bundle.
// Signals :
//   wrEn      write request (from user)
//   rdEn      read request (from user)
//   dataIn    write data, WIDTH bits (from user)
//   dataOut   registered read data, WIDTH bits (from FIFO)
//   empty     no words stored (from FIFO)
//   full      DEPTH words stored (from FIFO)
//   overflow  sticky, write attempted while full (only with SYNC_FIFO_ERR_FLAGS_EN)
//   underflow sticky, read attempted while empty (only with SYNC_FIFO_ERR_FLAGS_EN)
// Modports: master = user of the FIFO, slave = the FIFO itself.
// -----------------------------------------------------------------------------
interface sync_fifo_if #(
  parameter int WIDTH = sync_fifo_pkg::WIDTH_DEF
);

  logic             wrEn;
  logic             rdEn;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             empty;
  logic             full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;

  modport master (
    output wrEn, rdEn, dataIn,
    input  dataOut, empty, full, overflow, underflow
  );

  modport slave (
    input  wrEn, rdEn, dataIn,
    output dataOut, empty, full, overflow, underflow
  );
`else
  modport master (
    output wrEn, rdEn, dataIn,
    input  dataOut, empty, full
  );

  modport slave (
    input  wrEn, rdEn, dataIn,
    output dataOut, empty, full
  );
`endif

endinterface : sync_fifo_if

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Purpose : DEPTH x WIDTH register array with one synchronous write port and
//           one read port feeding a registered output.
// Ports   :
//   clk_i     clock
//   rst_i     async active-high reset, clears only the output register
//   wr_en_i   write strobe
//   waddr_i   write address
//   wdata_i   write data
//   rd_en_i   read strobe; rdata_o loads mem[raddr_i] at the edge
//   raddr_i   read address
//   rdata_o   registered read data, holds when rd_en_i is low
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : Single-clock FIFO, DEPTH words of WIDTH bits, registered read data
//           with one clock of latency, full/empty decoded from the pointers.
// Ports   :
//   clk   rising-edge clock
//   rstN  asynchronous reset, active-high despite the name
//   bus   sync_fifo_if.slave: wrEn, rdEn, dataIn, dataOut, empty, full
//         (+ overflow, underflow when SYNC_FIFO_ERR_FLAGS_EN is defined)
// Config  : SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic     clk,
  input  logic     rstN,
  sync_fifo_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          empty;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  // Equal pointers: empty. Same slot but different lap: full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Both requests qualify on the pre-edge flags, so a simultaneous
  // read/write on a full FIFO reads only, and on an empty FIFO writes only.
  assign wr_ok = bus.wrEn && !full;
  assign rd_ok = bus.rdEn && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (rd_ok) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rstN),
    .wr_en_i (wr_ok),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.dataIn),
    .rd_en_i (rd_ok),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (bus.dataOut)
  );

  assign bus.empty = empty;
  assign bus.full  = full;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (bus.wrEn && full);
    underflow_d = underflow_q || (bus.rdEn && empty);
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Purpose : Directed self-checking bench for sync_fifo (DEPTH=8, WIDTH=32).
//           Inputs change 1 time unit after each rising edge; outputs are
//           sampled at the same point, i.e. after the edge has settled.
// Config  : SYNC_FIFO_ERR_FLAGS_EN enables the sticky error flag checks.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  logic clk;
  logic rstN;
  int   tests_run;
  int   tests_failed;

  sync_fifo_if #(.WIDTH(32)) bus ();

  sync_fifo #(
    .DEPTH (8),
    .WIDTH (32)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests, returning #1 after the edge.
  task automatic cycle(input logic we, input logic re, input logic [31:0] din);
    bus.wrEn   = we;
    bus.rdEn   = re;
    bus.dataIn = din;
    @(posedge clk);
    #1;
    bus.wrEn   = 1'b0;
    bus.rdEn   = 1'b0;
    bus.dataIn = 32'h0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstN         = 1'b1;
    bus.wrEn     = 1'b0;
    bus.rdEn     = 1'b0;
    bus.dataIn   = 32'h0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("por_empty", {31'b0, bus.empty}, 32'd1);
    chk("por_full",  {31'b0, bus.full},  32'd0);
    chk("por_dout",  bus.dataOut,        32'h0);
    rstN = 1'b0;

    // 1. Reset asserted mid-run, asynchronously, with data stored
    cycle(1'b1, 1'b0, 32'h11);
    cycle(1'b0, 1'b1, 32'h0);
    chk("pre_rst_dout", bus.dataOut, 32'h11);
    cycle(1'b1, 1'b0, 32'h22);
    chk("pre_rst_nonempty", {31'b0, bus.empty}, 32'd0);
    rstN = 1'b1;
    #2;
    chk("mid_rst_empty", {31'b0, bus.empty}, 32'd1);
    chk("mid_rst_full",  {31'b0, bus.full},  32'd0);
    chk("mid_rst_dout",  bus.dataOut,        32'h0);
    #2;
    rstN = 1'b0;
    cycle(1'b0, 1'b1, 32'h0);
    chk("rd_after_rst_dout",  bus.dataOut,        32'h0);
    chk("rd_after_rst_empty", {31'b0, bus.empty}, 32'd1);

    // 2. Interleaved write/read
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, i);
      chk("il_not_empty", {31'b0, bus.empty}, 32'd0);
      cycle(1'b0, 1'b1, 32'h0);
      chk("il_dout",  bus.dataOut,        i);
      chk("il_empty", {31'b0, bus.empty}, 32'd1);
    end

    // 3. Fill, overfill, drain
    for (int i = 0; i < 8; i++) begin
      chk("fill_not_full", {31'b0, bus.full}, 32'd0);
      cycle(1'b1, 1'b0, 32'hA0 + i);
    end
    chk("fill_full", {31'b0, bus.full}, 32'd1);
    cycle(1'b1, 1'b0, 32'hFF);
    chk("overfill_full", {31'b0, bus.full}, 32'd1);
    chk("overfill_dout", bus.dataOut, 32'h7);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      chk("drain_dout", bus.dataOut, 32'hA0 + i);
      chk("drain_not_full", {31'b0, bus.full}, 32'd0);
    end
    chk("drain_empty", {31'b0, bus.empty}, 32'd1);
    cycle(1'b0, 1'b1, 32'h0);
    chk("underread_hold", bus.dataOut, 32'hA7);

    // 4. Wrap: offset the pointers, then a full lap
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h30 + i);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      chk("wrap3_dout", bus.dataOut, 32'h30 + i);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h40 + i);
    chk("wrap_full", {31'b0, bus.full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      chk("wrap8_dout", bus.dataOut, 32'h40 + i);
    end
    chk("wrap_empty", {31'b0, bus.empty}, 32'd1);

    // 5. Simultaneous read/write with 4 stored
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h50 + i);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 32'h60 + i);
      chk("sim_dout",  bus.dataOut,        32'h50 + i);
      chk("sim_empty", {31'b0, bus.empty}, 32'd0);
      chk("sim_full",  {31'b0, bus.full},  32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      chk("sim_tail_dout", bus.dataOut, 32'h60 + i);
    end
    chk("sim_tail_empty", {31'b0, bus.empty}, 32'd1);

    // Both asserted while full: read only, write dropped
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h70 + i);
    chk("simfull_full", {31'b0, bus.full}, 32'd1);
    cycle(1'b1, 1'b1, 32'hEE);
    chk("simfull_dout", bus.dataOut, 32'h70);
    chk("simfull_not_full", {31'b0, bus.full}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      chk("simfull_drain", bus.dataOut, 32'h70 + i);
    end
    chk("simfull_empty", {31'b0, bus.empty}, 32'd1);

    // Both asserted while empty: write only, dataOut holds
    cycle(1'b1, 1'b1, 32'h88);
    chk("simempty_hold",      bus.dataOut,        32'h77);
    chk("simempty_not_empty", {31'b0, bus.empty}, 32'd0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("simempty_dout",  bus.dataOut,        32'h88);
    chk("simempty_empty", {31'b0, bus.empty}, 32'd1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // 6. Sticky error flags
    rstN = 1'b1;
    #2;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    chk("err_rst_ovf", {31'b0, bus.overflow},  32'd0);
    chk("err_rst_unf", {31'b0, bus.underflow}, 32'd0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("unf_set",     {31'b0, bus.underflow}, 32'd1);
    chk("unf_ovf_clr", {31'b0, bus.overflow},  32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h90 + i);
    chk("ovf_pre", {31'b0, bus.overflow}, 32'd0);
    cycle(1'b1, 1'b0, 32'hFF);
    chk("ovf_set", {31'b0, bus.overflow}, 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("ovf_sticky", {31'b0, bus.overflow},  32'd1);
    chk("unf_sticky", {31'b0, bus.underflow}, 32'd1);
    rstN = 1'b1;
    #2;
    chk("err_clr_ovf", {31'b0, bus.overflow},  32'd0);
    chk("err_clr_unf", {31'b0, bus.underflow}, 32'd0);
    rstN = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sync_fifo
